// File: rtl/ds18b20_seq_pkg.sv
// Shared constants, FSM state/phase types and per-state op decode for ds18b20_seq.
package ds18b20_seq_pkg;

    localparam logic [7:0] OW_CMD_SKIP_ROM   = 8'hCC;
    localparam logic [7:0] OW_CMD_CONVERT_T  = 8'h44;
    localparam logic [7:0] OW_CMD_READ_SP    = 8'hBE;
    localparam int unsigned DEFAULT_CONV_CYCLES = 18_750_000;

    typedef enum logic [3:0] {
        ST_IDLE, ST_RST1, ST_SKIP1, ST_CONVT, ST_CONV_WAIT, ST_RST2,
        ST_SKIP2, ST_RDSP, ST_RDBYTE, ST_RDTERM, ST_FIN_OK, ST_FIN_ERR
    } state_t;

    typedef enum logic [1:0] {PH_ISSUE, PH_ACK, PH_WAIT} phase_t;
    typedef enum logic [1:0] {OP_RESET, OP_WRITE, OP_READ} op_t;

    function automatic op_t op_of(input state_t s);
        case (s)
            ST_RST1, ST_RST2, ST_RDTERM: op_of = OP_RESET;
            ST_RDBYTE:                   op_of = OP_READ;
            default:                     op_of = OP_WRITE;
        endcase
    endfunction

    function automatic logic [7:0] cmd_of(input state_t s);
        case (s)
            ST_SKIP1, ST_SKIP2: cmd_of = OW_CMD_SKIP_ROM;
            ST_CONVT:           cmd_of = OW_CMD_CONVERT_T;
            ST_RDSP:            cmd_of = OW_CMD_READ_SP;
            default:            cmd_of = 8'h00;
        endcase
    endfunction

    // Straight-line successor for ops that simply chain to the next one.
    function automatic state_t next_of(input state_t s);
        case (s)
            ST_RST1:  next_of = ST_SKIP1;
            ST_SKIP1: next_of = ST_CONVT;
            ST_CONVT: next_of = ST_CONV_WAIT;
            ST_RST2:  next_of = ST_SKIP2;
            ST_SKIP2: next_of = ST_RDSP;
            ST_RDSP:  next_of = ST_RDBYTE;
            default:  next_of = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ds18b20_seq_if.sv
// Byte-engine bus between the sequencer (master) and the one_wire engine (slave).
interface ds18b20_seq_if;
    logic       ow_reset;
    logic       ow_write_byte;
    logic       ow_read_byte;
    logic [7:0] ow_in_byte;
    logic [7:0] ow_out_byte;
    logic       ow_busy;
    logic       ow_presense;

    modport master (
        output ow_reset, ow_write_byte, ow_read_byte, ow_in_byte,
        input  ow_out_byte, ow_busy, ow_presense
    );

    modport slave (
        input  ow_reset, ow_write_byte, ow_read_byte, ow_in_byte,
        output ow_out_byte, ow_busy, ow_presense
    );
endinterface

// File: rtl/ds18b20_seq_crc8_dallas.sv
// Dallas/Maxim CRC8 (x^8+x^5+x^4+1, LSB-first, init 0) accumulated one byte per enable.
module crc8_dallas (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);
    logic [7:0] r_crc;
    logic [7:0] w_chain [0:8];

    assign w_chain[0] = r_crc;

    // One shift-register step per data bit, unrolled across the byte.
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        assign w_chain[gi+1] = {1'b0, w_chain[gi][7:1]}
                             ^ ({8{w_chain[gi][0] ^ data[gi]}} & 8'h8C);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) r_crc <= 8'h00;
        else if (en)    r_crc <= w_chain[8];
    end

    assign crc = r_crc;
endmodule

// File: rtl/ds18b20_seq.sv
// DS18B20 convert-and-read sequencer driving the one_wire byte engine.
// Optional scratchpad CRC check (9-byte read) enabled by defining DS18B20_CRC_EN.
module ds18b20_seq
    import ds18b20_seq_pkg::*;
#(
    parameter int unsigned CONV_CYCLES = DEFAULT_CONV_CYCLES,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 temp_valid,
    output logic [15:0]          temp,
    output logic                 err_no_dev,
    output logic                 err_crc,
    output logic                 err_timeout,
    ds18b20_seq_if.master        ow
);
`ifdef DS18B20_CRC_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd1;
`endif

    state_t      r_state;
    phase_t      r_phase;
    logic [31:0] r_ack_cnt, r_conv_cnt;
    logic [3:0]  r_idx;
    logic        r_present;
    logic [15:0] r_shadow, r_temp;
    logic        r_done, r_temp_valid, r_err_no_dev, r_err_crc, r_err_timeout;
    logic        r_ow_reset, r_ow_write, r_ow_read;
    logic [7:0]  r_in_byte;
    logic        w_accept, w_present, w_crc_bad;

    assign w_accept  = start && !ow.ow_busy;
    assign w_present = r_present || ow.ow_presense;

`ifdef DS18B20_CRC_EN
    logic [7:0] w_crc;
    logic       w_crc_clr, w_crc_en;

    assign w_crc_clr = (r_state == ST_IDLE) && w_accept;
    assign w_crc_en  = (r_state == ST_RDBYTE) && (r_phase == PH_WAIT)
                     && !ow.ow_busy && (r_idx < LAST_IDX);
    assign w_crc_bad = (ow.ow_out_byte != w_crc);

    crc8_dallas u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_crc_clr),
        .en   (w_crc_en),
        .data (ow.ow_out_byte),
        .crc  (w_crc)
    );
`else
    assign w_crc_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;      r_phase <= PH_ISSUE;
            r_ack_cnt <= '0;         r_conv_cnt <= '0;
            r_idx <= '0;             r_present <= 1'b0;
            r_shadow <= '0;          r_temp <= '0;
            r_done <= 1'b0;          r_temp_valid <= 1'b0;
            r_err_no_dev <= 1'b0;    r_err_crc <= 1'b0;    r_err_timeout <= 1'b0;
            r_ow_reset <= 1'b0;      r_ow_write <= 1'b0;   r_ow_read <= 1'b0;
            r_in_byte <= '0;
        end else begin
            r_ow_reset <= 1'b0;  r_ow_write <= 1'b0;  r_ow_read <= 1'b0;
            r_done <= 1'b0;      r_temp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_err_no_dev <= 1'b0; r_err_crc <= 1'b0; r_err_timeout <= 1'b0;
                    r_idx <= '0;
                    r_state <= ST_RST1;   r_phase <= PH_ISSUE;
                end
                ST_CONV_WAIT: if (r_conv_cnt == CONV_CYCLES - 1) begin
                    r_state <= ST_RST2;   r_phase <= PH_ISSUE;
                end else begin
                    r_conv_cnt <= r_conv_cnt + 32'd1;
                end
                ST_FIN_OK, ST_FIN_ERR: r_state <= ST_IDLE;
                default: case (r_phase)
                    PH_ISSUE: begin
                        case (op_of(r_state))
                            OP_RESET: r_ow_reset <= 1'b1;
                            OP_READ:  r_ow_read  <= 1'b1;
                            default: begin
                                r_ow_write <= 1'b1;
                                r_in_byte  <= cmd_of(r_state);
                            end
                        endcase
                        r_ack_cnt <= '0;
                        r_present <= ow.ow_presense;
                        r_phase   <= PH_ACK;
                    end
                    PH_ACK: begin
                        r_present <= w_present;
                        if (ow.ow_busy) begin
                            r_phase <= PH_WAIT;
                        end else if (r_ack_cnt == ACK_TIMEOUT - 1) begin
                            r_err_timeout <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_FIN_ERR;
                        end else begin
                            r_ack_cnt <= r_ack_cnt + 32'd1;
                        end
                    end
                    default: begin
                        r_present <= w_present;
                        if (!ow.ow_busy) begin
                            r_phase <= PH_ISSUE;
                            case (r_state)
                                ST_RST1, ST_RST2: if (!w_present) begin
                                    r_err_no_dev <= 1'b1;
                                    r_done  <= 1'b1;
                                    r_state <= ST_FIN_ERR;
                                end else begin
                                    r_state <= next_of(r_state);
                                end
                                ST_CONVT: begin
                                    r_conv_cnt <= '0;
                                    r_state    <= ST_CONV_WAIT;
                                end
                                ST_RDBYTE: begin
                                    if (r_idx == 4'd0) r_shadow[7:0]  <= ow.ow_out_byte;
                                    if (r_idx == 4'd1) r_shadow[15:8] <= ow.ow_out_byte;
                                    if (r_idx != LAST_IDX) begin
                                        r_idx <= r_idx + 4'd1;
                                    end else if (w_crc_bad) begin
                                        // Bad scratchpad: bail out without the terminating reset.
                                        r_err_crc <= 1'b1;
                                        r_done  <= 1'b1;
                                        r_state <= ST_FIN_ERR;
                                    end else begin
                                        r_state <= ST_RDTERM;
                                    end
                                end
                                ST_RDTERM: begin
                                    r_temp       <= r_shadow;
                                    r_done       <= 1'b1;
                                    r_temp_valid <= 1'b1;
                                    r_state      <= ST_FIN_OK;
                                end
                                default: r_state <= next_of(r_state);
                            endcase
                        end
                    end
                endcase
            endcase
        end
    end

    assign busy             = (r_state != ST_IDLE) || ow.ow_busy;
    assign done             = r_done;
    assign temp_valid       = r_temp_valid;
    assign temp             = r_temp;
    assign err_no_dev       = r_err_no_dev;
    assign err_crc          = r_err_crc;
    assign err_timeout      = r_err_timeout;
    assign ow.ow_reset      = r_ow_reset;
    assign ow.ow_write_byte = r_ow_write;
    assign ow.ow_read_byte  = r_ow_read;
    assign ow.ow_in_byte    = r_in_byte;
endmodule

// File: tb/tb_ds18b20_seq.sv
// Scoreboard bench for ds18b20_seq with a behavioural one_wire engine model.
module tb_ds18b20_seq;
    import ds18b20_seq_pkg::*;

    localparam int OP_LEN = 4;
    localparam int BUDGET = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, temp_valid, err_no_dev, err_crc, err_timeout;
    logic [15:0] temp;

    ds18b20_seq_if ow_if ();

    ds18b20_seq #(.CONV_CYCLES(20), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .temp_valid(temp_valid), .temp(temp), .err_no_dev(err_no_dev),
        .err_crc(err_crc), .err_timeout(err_timeout), .ow(ow_if)
    );

    always #5 clk = ~clk;

    // ---------------- engine model ----------------
    logic        dev_present = 1'b1;
    logic        busy_en = 1'b1;
    logic [7:0]  sp [0:8];
    logic        m_busy = 1'b0, m_pres = 1'b0, m_rd = 1'b0;
    logic [7:0]  m_out = 8'h00;
    int          m_left = 0, m_rd_idx = 0;
    int          cyc = 0, wr_cnt = 0, rst_cnt = 0, rst_cyc = 0;
    logic [31:0] wr_log = 32'h0;

    assign ow_if.ow_busy     = m_busy;
    assign ow_if.ow_presense = m_pres;
    assign ow_if.ow_out_byte = m_out;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ow_if.ow_write_byte) begin
            wr_cnt <= wr_cnt + 1;
            wr_log <= {wr_log[23:0], ow_if.ow_in_byte};
        end
        if (ow_if.ow_reset) begin
            rst_cnt <= rst_cnt + 1;
            rst_cyc <= cyc;
        end
        if (busy_en && (ow_if.ow_reset || ow_if.ow_write_byte || ow_if.ow_read_byte)) begin
            m_busy <= 1'b1;
            m_left <= OP_LEN;
            m_rd   <= ow_if.ow_read_byte;
            m_pres <= ow_if.ow_reset && dev_present;
            if (ow_if.ow_reset) m_rd_idx <= 0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_pres <= 1'b0;
                if (m_rd && m_rd_idx < 9) begin
                    m_out    <= sp[m_rd_idx];
                    m_rd_idx <= m_rd_idx + 1;
                end
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        tv;
        logic [15:0] temp;
        logic        nd, crc, tmo;
        int          n_wr, n_rst, lat, base_wr, base_rst;
    } exp_t;

    typedef struct {
        logic        busy, done, tv, nd, crc, tmo, q_empty;
        logic [15:0] temp;
    } snap_t;

    exp_t  exp_q [$];
    snap_t snap_q [$];
    int    checks = 0, errors = 0;
    int    done_cnt = 0, tmo_cnt = 0, tmo_seen = 0, txn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (tmo_cnt != tmo_seen) begin
            checks++; errors++; tmo_seen++;
            $display("FAIL wait_done: got no done within %0d cycles expected done", BUDGET);
        end
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: done temp=%04h valid=%0b no_dev=%0b crc=%0b tmo=%0b writes=%0d resets=%0d",
                         txn, temp, temp_valid, err_no_dev, err_crc, err_timeout,
                         wr_cnt - e.base_wr, rst_cnt - e.base_rst);
                chk("temp_valid", 32'(temp_valid), 32'(e.tv));
                chk("temp", 32'(temp), 32'(e.temp));
                chk("err_no_dev", 32'(err_no_dev), 32'(e.nd));
                chk("err_crc", 32'(err_crc), 32'(e.crc));
                chk("err_timeout", 32'(err_timeout), 32'(e.tmo));
                chk("write_count", 32'(wr_cnt - e.base_wr), 32'(e.n_wr));
                chk("reset_count", 32'(rst_cnt - e.base_rst), 32'(e.n_rst));
                if (e.n_wr == 4) chk("write_bytes", wr_log, 32'hCC44CCBE);
                if (e.lat >= 0) chk("timeout_latency", 32'(cyc - rst_cyc), 32'(e.lat));
            end
        end
        if (snap_q.size() != 0) begin
            snap_t s;
            s = snap_q.pop_front();
            chk("snap_busy", 32'(busy), 32'(s.busy));
            chk("snap_done", 32'(done), 32'(s.done));
            chk("snap_temp_valid", 32'(temp_valid), 32'(s.tv));
            chk("snap_temp", 32'(temp), 32'(s.temp));
            chk("snap_errs", {29'd0, err_no_dev, err_crc, err_timeout}, {29'd0, s.nd, s.crc, s.tmo});
            chk("snap_strobes", {29'd0, ow_if.ow_reset, ow_if.ow_write_byte, ow_if.ow_read_byte}, 32'd0);
            if (s.q_empty) chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    function automatic exp_t mk(input logic tv, input logic [15:0] t, input logic nd,
                                input logic c, input logic tm, input int nw, input int nr, input int lat);
        exp_t e;
        e.tv = tv; e.temp = t; e.nd = nd; e.crc = c; e.tmo = tm;
        e.n_wr = nw; e.n_rst = nr; e.lat = lat; e.base_wr = 0; e.base_rst = 0;
        return e;
    endfunction

    task automatic push_exp(input exp_t e_in);
        exp_t e;
        e = e_in;
        e.base_wr  = wr_cnt;
        e.base_rst = rst_cnt;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input logic [15:0] t, input logic nd, input logic c,
                             input logic tm, input logic qe);
        snap_t s;
        s.busy = 1'b0; s.done = 1'b0; s.tv = 1'b0; s.temp = t;
        s.nd = nd; s.crc = c; s.tmo = tm; s.q_empty = qe;
        @(posedge clk); #1;
        snap_q.push_back(s);
        while (snap_q.size() != 0) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < BUDGET) begin
            @(negedge clk); n++;
        end
        if (done_cnt == d0) tmo_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input exp_t e);
        int d0;
        push_exp(e);
        d0 = done_cnt;
        pulse_start();
        wait_done(d0);
    endtask

`ifdef DS18B20_CRC_EN
    localparam int N_WR_GOOD = 4;
`else
    localparam int N_WR_GOOD = 4;
`endif

    initial begin
        int d0, n;
        sp[0] = 8'h50; sp[1] = 8'h05; sp[2] = 8'h4B; sp[3] = 8'h46; sp[4] = 8'h7F;
        sp[5] = 8'hFF; sp[6] = 8'h0C; sp[7] = 8'h10; sp[8] = 8'h1C;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        push_idle(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // No device on the bus: only the first reset is issued.
        dev_present = 1'b0;
        run(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1, -1));
        dev_present = 1'b1;

        // Good read: 85.0 C.
        run(mk(1'b1, 16'h0550, 1'b0, 1'b0, 1'b0, N_WR_GOOD, 3, -1));

`ifdef DS18B20_CRC_EN
        // Corrupted CRC byte: no terminating reset, temp kept.
        sp[8] = 8'h1D;
        run(mk(1'b0, 16'h0550, 1'b0, 1'b1, 1'b0, 4, 2, -1));
        sp[8] = 8'h1C;
`endif

        // Engine never acknowledges.
        busy_en = 1'b0;
        run(mk(1'b0, 16'h0550, 1'b0, 1'b0, 1'b1, 0, 1, 16));
        busy_en = 1'b1;
        push_idle(16'h0550, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset while waiting for conversion.
        n = wr_cnt;
        pulse_start();
        d0 = 0;
        while (!(wr_cnt == n + 2 && !m_busy) && d0 < BUDGET) begin
            @(negedge clk); d0++;
        end
        if (wr_cnt != n + 2) tmo_cnt++;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        begin
            snap_t s;
            s.busy = 1'b0; s.done = 1'b0; s.tv = 1'b0; s.temp = 16'h0000;
            s.nd = 1'b0; s.crc = 1'b0; s.tmo = 1'b0; s.q_empty = 1'b1;
            snap_q.push_back(s);
        end
        repeat (40) @(negedge clk);
        run(mk(1'b1, 16'h0550, 1'b0, 1'b0, 1'b0, N_WR_GOOD, 3, -1));

        // Second start during the scratchpad read must be ignored.
        push_exp(mk(1'b1, 16'h0550, 1'b0, 1'b0, 1'b0, N_WR_GOOD, 3, -1));
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (!ow_if.ow_read_byte && n < BUDGET) begin
            @(negedge clk); n++;
        end
        if (!ow_if.ow_read_byte) tmo_cnt++;
        pulse_start();
        wait_done(d0);
        repeat (200) @(negedge clk);
        push_idle(16'h0550, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ds18b20_seq.md
# ds18b20_seq

Conversion sequencer for the 1-wire byte engine (`one_wire`). On a single `start` pulse it drives the engine through a complete DS18B20 temperature read:

- reset/presence
- Skip ROM, Convert T, conversion wait
- reset, Skip ROM, Read Scratchpad, scratchpad byte reads

It then returns the 16-bit raw temperature with status flags. It sits between the SPI command decoder and `one_wire`, in the `clk0` domain.

## Interface
- `CONV_CYCLES`, 18_750_000: conversion wait in clocks (750 ms at 25 MHz); benches override small.
- `ACK_TIMEOUT`, 16: max clocks from engine strobe to `ow_busy` rising.
- `clk`  in  1  system clock (25 MHz `clk0`). One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to run a sequence.
- `busy`  out  1  sequence in progress (FSM not IDLE) OR `ow_busy`.
- `done`  out  1  one-cycle pulse, sequence ended (success or error).
- `temp_valid`  out  1  one-cycle pulse with `done` on success.
- `temp`  out  16  {scratchpad byte1, byte0}; held until next success.
- `err_no_dev`, `err_crc`, `err_timeout`  out  1 each  sticky until next accepted `start`.
- `ow_reset`, `ow_write_byte`, `ow_read_byte`  out  1  one-cycle engine strobes.
- `ow_in_byte`  out  8  byte to write; stable from strobe until `ow_busy` falls.
- `ow_out_byte`  in  8  byte read by engine; valid when `ow_busy` falls after read.
- `ow_busy`  in  1  engine busy.
- `ow_presense`  in  1  presence seen during engine reset.

## Operation
**Reset values.** All outputs are 0 after `rst`: `temp`=0, flags clear, strobes low, FSM=IDLE. Reset mid-sequence aborts immediately: no strobe or `done` is issued on the following cycle. The engine itself is not reset.

**Start acceptance.** `start` is accepted only in IDLE with `ow_busy`=0. It is otherwise ignored, with no queuing. Acceptance clears the three error flags.

**Op handshake.** Every engine op runs three phases:
- ISSUE: strobe high for 1 cycle, `ow_in_byte` loaded.
- ACK: wait for `ow_busy`=1. Timeout after `ACK_TIMEOUT` cycles sets `err_timeout` and goes to FIN_ERR.
- WAIT: wait for `ow_busy`=0.

During a reset op, `ow_presense`=1 on any cycle from ISSUE to WAIT exit latches "present".

**States.** IDLE → RST1 → SKIP1 (0xCC) → CONVT (0x44) → CONV_WAIT → RST2 → SKIP2 (0xCC) → RDSP (0xBE) → RDBYTE → FIN_OK / FIN_ERR → IDLE.
- CONV_WAIT counts `CONV_CYCLES` clocks, then proceeds.
- RST1 or RST2 ending without presence sets `err_no_dev` and goes to FIN_ERR. No further strobes are issued.
- RDBYTE repeats a read op N times. Byte index 0 is stored to `temp[7:0]`, index 1 to `temp[15:8]`, through a shadow register. `temp` updates only in FIN_OK.
- After the last byte, one RST op terminates the read, ignoring presence, then FIN_OK.
- FIN_OK: `done`=`temp_valid`=1 for one cycle. FIN_ERR: `done`=1, `temp_valid`=0, `temp` unchanged.

## Timing
- Strobe asserts on the cycle after state entry.
- `done` asserts the cycle after the final `ow_busy`=0 sample.
- A `start` is accepted at the earliest on the cycle after `done`, since FSM=IDLE then.
- `busy` rises on the cycle after the accepted `start`.
- Total latency = engine op times + `CONV_CYCLES` + 3 cycles per op + 2.
- ACK timeout counter starts at 0 in the strobe cycle. `err_timeout` sets when the count reaches `ACK_TIMEOUT`-1 with `ow_busy` still 0.

## Configuration
`DS18B20_CRC_EN`:
- **Defined:** N=9 bytes. Dallas CRC8 (x^8+x^5+x^4+1, LSB-first, init 0x00) is accumulated over bytes 0–7 as each byte lands. Byte 8 is compared to the accumulated CRC in the cycle it lands. On mismatch, set `err_crc`, skip the terminating RST, and go to FIN_ERR. An all-zero scratchpad is treated as a CRC pass, by the CRC's own arithmetic.
- **Undefined:** N=2. `err_crc` is tied 0. The terminating RST is mandatory.

## Structure
- **Shared package:** command constants `OW_CMD_SKIP_ROM`=0xCC, `OW_CMD_CONVERT_T`=0x44, `OW_CMD_READ_SP`=0xBE; the state enum; default `CONV_CYCLES`.
- **Sub-module:** `crc8_dallas`, a byte-wide combinational next-CRC function plus register, with `clr` and `en` inputs. Instantiated only under `DS18B20_CRC_EN`.

## Test plan
- **No device:** `ow_presense` stays 0 → after RST1, `done`=1, `err_no_dev`=1, `temp_valid`=0, and zero write strobes issued.
- **Good read:** model returns 50 05 4B 46 7F FF 0C 10 1C → writes CC 44 CC BE in order; `temp`=0x0550, `temp_valid`=1, all errors 0 (CRC on).
- **Bad CRC** (CRC on): last byte 0x1D → `err_crc`=1, `temp` retains previous value, no terminating RST.
- **Timeout:** model never raises `ow_busy` → `err_timeout`=1 and `done` exactly `ACK_TIMEOUT` cycles after the first `ow_reset`.
- **Reset mid-CONV_WAIT:** `rst` pulse → next cycle all outputs 0, FSM IDLE. A subsequent `start` runs a full good sequence.
- **Start while busy:** second `start` during RDBYTE is ignored → exactly one `done`, and flags from the first run unchanged.
